// File: rtl/mem_sys_pkg.sv
// rtl/mem_sys_pkg.sv - shared port ids, in-flight tag and occupancy state types for the program memory path
package mem_sys_pkg;

  localparam logic PORT_FETCH = 1'b0;
  localparam logic PORT_LOAD  = 1'b1;

  localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h0040_0000;

  typedef struct packed {
    logic valid;
    logic port;
    logic err;
  } tag_t;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

endpackage

// File: rtl/rr_arbiter2.sv
// rtl/rr_arbiter2.sv - two-requester round-robin arbiter; a tie goes to the port not granted last
module rr_arbiter2
  import mem_sys_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_q,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = (last_q == PORT_LOAD) ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/program_memory_arbiter.sv
// rtl/program_memory_arbiter.sv - fetch/load sharing of one ROM read port with tagged in-flight responses
// Optional address range checking is enabled with PMA_RANGE_CHECK_EN.
module program_memory_arbiter
  import mem_sys_pkg::*;
#(
  parameter int                    DATA_WIDTH   = 32,
  parameter int                    MEMORY_DEPTH = 64,
  parameter logic [DATA_WIDTH-1:0] BASE_ADDR    = DEFAULT_BASE_ADDR,
  parameter int                    READ_LATENCY = 1
) (
  input  logic                            Clk_i,
  input  logic                            Reset_n_i,
  input  logic [1:0]                      Req_i,
  input  logic [DATA_WIDTH-1:0]           Addr0_i,
  input  logic [DATA_WIDTH-1:0]           Addr1_i,
  output logic [1:0]                      Gnt_o,
  output logic [1:0]                      Rvalid_o,
  output logic [DATA_WIDTH-1:0]           Rdata_o,
  output logic                            Err_o,
  output logic                            Mem_En_o,
  output logic [$clog2(MEMORY_DEPTH)-1:0] Mem_Addr_o,
  input  logic [DATA_WIDTH-1:0]           Mem_Data_i
);

  localparam int AW = $clog2(MEMORY_DEPTH);

  logic                  last_q;
  state_t                state_q, state_d;
  tag_t                  tag_q [READ_LATENCY];
  tag_t                  head, tail;
  logic [1:0]            arb_gnt, gnt;
  logic                  granted, range_err, pending;
  logic [DATA_WIDTH-1:0] sel_addr;

  rr_arbiter2 u_arb (
    .req    (Req_i),
    .last_q (last_q),
    .gnt    (arb_gnt)
  );

  // The grant is combinational, so it must be masked explicitly while reset is held.
  assign gnt      = Reset_n_i ? arb_gnt : 2'b00;
  assign granted  = |gnt;
  assign sel_addr = gnt[PORT_LOAD] ? Addr1_i : Addr0_i;

`ifdef PMA_RANGE_CHECK_EN
  localparam logic [DATA_WIDTH-1:0] LIMIT_ADDR = BASE_ADDR + DATA_WIDTH'(4 * MEMORY_DEPTH);
  assign range_err = (sel_addr[1:0] != 2'b00) || (sel_addr < BASE_ADDR) || (sel_addr >= LIMIT_ADDR);
`else
  assign range_err = 1'b0;
`endif

  assign Gnt_o      = gnt;
  assign Mem_En_o   = granted && !range_err;
  assign Mem_Addr_o = granted ? AW'((sel_addr - BASE_ADDR) >> 2) : '0;

  assign head = '{valid: granted, port: gnt[PORT_LOAD], err: granted && range_err};
  assign tail = tag_q[READ_LATENCY-1];

  always_ff @(posedge Clk_i) begin
    if (!Reset_n_i) begin
      for (int i = 0; i < READ_LATENCY; i++) tag_q[i] <= '0;
      last_q  <= PORT_LOAD;
      state_q <= IDLE;
    end else begin
      tag_q[0] <= head;
      for (int i = 1; i < READ_LATENCY; i++) tag_q[i] <= tag_q[i-1];
      if (granted) last_q <= gnt[PORT_LOAD];
      state_q <= state_d;
    end
  end

  // Tags that will still be in flight after this cycle's tail retires.
  always_comb begin
    pending = 1'b0;
    for (int i = 0; i < READ_LATENCY - 1; i++) pending = pending | tag_q[i].valid;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (granted) state_d = ACTIVE;
      ACTIVE:  if (!granted && !pending) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    Rvalid_o = 2'b00;
    Rdata_o  = '0;
    Err_o    = 1'b0;
    if (Reset_n_i && tail.valid) begin
      Rvalid_o[tail.port] = 1'b1;
      Err_o               = tail.err;
      Rdata_o             = tail.err ? '0 : Mem_Data_i;
    end
  end

endmodule

// File: tb/tb_program_memory_arbiter.sv
// tb/tb_program_memory_arbiter.sv - scoreboard bench driving latency 1, 2 and 3 arbiters in lockstep
module tb_program_memory_arbiter;
  import mem_sys_pkg::*;

  localparam logic [31:0] BASE = 32'h0040_0000;

  typedef struct {
    logic        port;
    logic [31:0] data;
    logic        err;
    int          due;
  } exp_t;

  logic        clk;
  logic        rstn;
  logic [1:0]  req;
  logic [31:0] addr0, addr1;

  logic [1:0]  gnt_w   [3];
  logic [1:0]  rvalid_w[3];
  logic [31:0] rdata_w [3];
  logic        err_w   [3];
  logic        en_w    [3];
  logic [5:0]  maddr_w [3];
  logic [31:0] mdata   [3];

  logic [5:0]  ap1;
  logic [5:0]  ap2 [2];
  logic [5:0]  ap3 [3];

  exp_t        sbq [3][$];
  int          nvec, nfail, cyc;
  logic        last_m;

  function automatic logic [31:0] rom_word(input logic [5:0] i);
    return 32'h1000_0000 + 32'(i) * 32'h0101_0011;
  endfunction

  program_memory_arbiter #(.READ_LATENCY(1)) dut1 (
    .Clk_i(clk), .Reset_n_i(rstn), .Req_i(req), .Addr0_i(addr0), .Addr1_i(addr1),
    .Gnt_o(gnt_w[0]), .Rvalid_o(rvalid_w[0]), .Rdata_o(rdata_w[0]), .Err_o(err_w[0]),
    .Mem_En_o(en_w[0]), .Mem_Addr_o(maddr_w[0]), .Mem_Data_i(mdata[0]));

  program_memory_arbiter #(.READ_LATENCY(2)) dut2 (
    .Clk_i(clk), .Reset_n_i(rstn), .Req_i(req), .Addr0_i(addr0), .Addr1_i(addr1),
    .Gnt_o(gnt_w[1]), .Rvalid_o(rvalid_w[1]), .Rdata_o(rdata_w[1]), .Err_o(err_w[1]),
    .Mem_En_o(en_w[1]), .Mem_Addr_o(maddr_w[1]), .Mem_Data_i(mdata[1]));

  program_memory_arbiter #(.READ_LATENCY(3)) dut3 (
    .Clk_i(clk), .Reset_n_i(rstn), .Req_i(req), .Addr0_i(addr0), .Addr1_i(addr1),
    .Gnt_o(gnt_w[2]), .Rvalid_o(rvalid_w[2]), .Rdata_o(rdata_w[2]), .Err_o(err_w[2]),
    .Mem_En_o(en_w[2]), .Mem_Addr_o(maddr_w[2]), .Mem_Data_i(mdata[2]));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ROM models with 1, 2 and 3 cycles of read latency.
  always @(posedge clk) begin
    ap1    <= maddr_w[0];
    ap2[0] <= maddr_w[1];
    ap2[1] <= ap2[0];
    ap3[0] <= maddr_w[2];
    ap3[1] <= ap3[0];
    ap3[2] <= ap3[1];
  end

  assign mdata[0] = rom_word(ap1);
  assign mdata[1] = rom_word(ap2[1]);
  assign mdata[2] = rom_word(ap3[2]);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    nvec++;
    assert (obs === expv) else begin
      nfail++;
      $error("FAIL %s cycle=%0d observed=%h expected=%h", tag, cyc, obs, expv);
    end
  endtask

  task automatic step(input logic rn, input logic [1:0] r, input logic [31:0] a0, input logic [31:0] a1);
    logic [1:0]  eg;
    logic [31:0] sa;
    logic        eerr;
    logic [5:0]  eidx;
    exp_t        e;
    rstn  = rn;
    req   = r;
    addr0 = a0;
    addr1 = a1;
    @(negedge clk);

    if (!rn) eg = 2'b00;
    else if (r == 2'b01) eg = 2'b01;
    else if (r == 2'b10) eg = 2'b10;
    else if (r == 2'b11) eg = last_m ? 2'b01 : 2'b10;
    else eg = 2'b00;

    sa   = eg[1] ? a1 : a0;
    eidx = 6'((sa - BASE) >> 2);
`ifdef PMA_RANGE_CHECK_EN
    eerr = (sa[1:0] != 2'b00) || (sa < BASE) || (sa >= BASE + 32'd256);
`else
    eerr = 1'b0;
`endif

    if (!rn) begin
      for (int k = 0; k < 3; k++) sbq[k].delete();
      last_m = 1'b1;
    end else begin
      chk("state_lat3", 32'(dut3.state_q == ACTIVE), 32'(sbq[2].size() != 0));
    end

    for (int k = 0; k < 3; k++) begin
      if (sbq[k].size() > 0 && sbq[k][0].due == cyc) begin
        e = sbq[k].pop_front();
        chk($sformatf("rvalid_lat%0d", k + 1), 32'(rvalid_w[k]), e.port ? 32'd2 : 32'd1);
        chk($sformatf("rdata_lat%0d", k + 1), rdata_w[k], e.data);
        chk($sformatf("err_lat%0d", k + 1), 32'(err_w[k]), 32'(e.err));
      end else begin
        chk($sformatf("rvalid_idle_lat%0d", k + 1), 32'(rvalid_w[k]), 32'd0);
        chk($sformatf("err_idle_lat%0d", k + 1), 32'(err_w[k]), 32'd0);
      end
    end

    chk("gnt", 32'(gnt_w[0]), 32'(eg));
    chk("gnt_lat3", 32'(gnt_w[2]), 32'(eg));
    chk("mem_en", 32'(en_w[0]), 32'((eg != 2'b00) && !eerr));
    if (eg != 2'b00 && !eerr) chk("mem_addr", 32'(maddr_w[0]), 32'(eidx));
    if (!rn) chk("mem_addr_rst", 32'(maddr_w[0]), 32'd0);

    if (eg != 2'b00) begin
      for (int k = 0; k < 3; k++) begin
        e.port = eg[1];
        e.err  = eerr;
        e.data = eerr ? 32'd0 : rom_word(eidx);
        e.due  = cyc + k + 1;
        sbq[k].push_back(e);
      end
      last_m = eg[1];
    end

    @(posedge clk);
    #1;
    cyc++;
  endtask

  initial begin
    nvec   = 0;
    nfail  = 0;
    cyc    = 0;
    last_m = 1'b1;
    rstn   = 1'b0;
    req    = 2'b00;
    addr0  = '0;
    addr1  = '0;

    step(1'b0, 2'b11, BASE, BASE + 4);
    step(1'b0, 2'b00, BASE, BASE + 4);

    step(1'b1, 2'b01, 32'h0040_0008, BASE);
    repeat (3) step(1'b1, 2'b00, BASE, BASE);

    repeat (4) step(1'b1, 2'b11, 32'h0040_0000, 32'h0040_0004);
    repeat (3) step(1'b1, 2'b00, BASE, BASE);

    repeat (3) step(1'b1, 2'b10, BASE, 32'h0040_0010);

    step(1'b1, 2'b10, BASE, 32'h0040_0102);
    step(1'b1, 2'b01, 32'h003F_FFFC, BASE);
    step(1'b1, 2'b10, BASE, 32'h0040_0100);
    step(1'b1, 2'b01, 32'h0040_00FC, BASE);
    repeat (3) step(1'b1, 2'b00, BASE, BASE);

    step(1'b1, 2'b11, 32'h0040_0020, 32'h0040_0024);
    step(1'b1, 2'b01, 32'h0040_0028, BASE);
    step(1'b0, 2'b00, BASE, BASE);
    repeat (3) step(1'b1, 2'b00, BASE, BASE);
    step(1'b1, 2'b11, 32'h0040_0030, 32'h0040_0034);
    step(1'b1, 2'b11, 32'h0040_0030, 32'h0040_0034);

    for (int i = 0; i < 30; i++) begin
      step(1'b1, 2'($urandom_range(0, 3)),
           BASE + 32'($urandom_range(0, 70)) * 4 + (($urandom_range(0, 7) == 0) ? 32'd2 : 32'd0),
           BASE + 32'($urandom_range(0, 70)) * 4);
    end
    repeat (4) step(1'b1, 2'b00, BASE, BASE);

    for (int k = 0; k < 3; k++) chk($sformatf("drained_lat%0d", k + 1), 32'(sbq[k].size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
